// File: rtl/obj_line_sequencer.sv
// Per-scanline OBJ row builder: clears the back buffer half, then walks OAM 0..127
// and streams each covering object's row pixels into the buffer, one line ahead of display.
module obj_line_sequencer #(
  parameter int CYCLE_BUDGET = 1210
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        line_start_i,
  input  logic [7:0]  line_i,
  output logic [6:0]  oam_idx_o,
  input  logic [7:0]  obj_y_i,
  input  logic [8:0]  obj_x_i,
  input  logic [6:0]  obj_w_i,
  input  logic [6:0]  obj_h_i,
  input  logic        obj_disable_i,
  input  logic        obj_pal256_i,
  output logic        pix_req_o,
  output logic [6:0]  pix_obj_o,
  output logic [5:0]  pix_line_o,
  output logic [5:0]  pix_idx_o,
  input  logic        pix_valid_i,
  input  logic [15:0] pix_data_i,
  input  logic        pix_transparent_i,
  output logic [7:0]  buf_row_o,
  output logic        buf_clear_o,
  output logic        buf_we_o,
  output logic [7:0]  buf_wcol_o,
  output logic [15:0] buf_wdata_o,
  output logic        buf_palettemode_o,
  output logic        buf_transparent_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        overrun_o
);
  localparam int CW = $clog2(CYCLE_BUDGET + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, OAM_RD, OAM_CHK, FETCH, DONE} state_t;

  state_t        state_q;
  logic [7:0]    buf_row_q, pend_line_q;
  logic          pend_q;
  logic [6:0]    idx_q, w_q;
  logic [8:0]    x_q;
  logic [5:0]    i_q, dy_q;
  logic          pal_q;
  logic [CW-1:0] cnt_q;
  logic          pix_req_q, buf_clear_q, buf_we_q, buf_pal_q;
  logic [7:0]    buf_wcol_q;
  logic [15:0]   buf_wdata_q;
  logic          busy_q, done_q, overrun_q;

  logic [7:0] dy_d;
  logic [5:0] i_d;
  logic [8:0] col_next_d;
  logic       hit_d, last_px_d, last_obj_d, active_d, budget_d;

  always_comb begin
    dy_d       = buf_row_q - obj_y_i;
    hit_d      = !obj_disable_i && (dy_d < {1'b0, obj_h_i});
    i_d        = i_q + 6'd1;
    col_next_d = x_q + {3'b000, i_d};
    last_px_d  = ({1'b0, i_q} == (w_q - 7'd1));
    last_obj_d = (idx_q == 7'd127);
    active_d   = (state_q == OAM_RD) || (state_q == OAM_CHK) || (state_q == FETCH);
    budget_d   = active_d && (cnt_q == CW'(CYCLE_BUDGET));
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      buf_row_q   <= '0;
      pend_line_q <= '0;
      pend_q      <= 1'b0;
      idx_q       <= '0;
      w_q         <= '0;
      x_q         <= '0;
      i_q         <= '0;
      dy_q        <= '0;
      pal_q       <= 1'b0;
      cnt_q       <= '0;
      pix_req_q   <= 1'b0;
      buf_clear_q <= 1'b0;
      buf_we_q    <= 1'b0;
      buf_pal_q   <= 1'b0;
      buf_wcol_q  <= '0;
      buf_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      buf_clear_q <= 1'b0;
      buf_we_q    <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      if (active_d) cnt_q <= cnt_q + CW'(1);

      // An abort or budget expiry drops any pending request; a write already registered still issues.
      if (line_start_i && (active_d || state_q == CLEAR)) begin
        pend_q      <= 1'b1;
        pend_line_q <= line_i;
        pix_req_q   <= 1'b0;
        done_q      <= 1'b1;
        overrun_q   <= 1'b1;
        state_q     <= DONE;
      end else if (budget_d) begin
        pix_req_q <= 1'b0;
        done_q    <= 1'b1;
        overrun_q <= 1'b1;
        state_q   <= DONE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (line_start_i) begin
              buf_row_q   <= line_i;
              idx_q       <= '0;
              buf_clear_q <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= CLEAR;
            end
          end
          CLEAR: begin
            cnt_q   <= '0;
            state_q <= OAM_RD;
          end
          OAM_RD: state_q <= OAM_CHK;
          OAM_CHK: begin
            if (hit_d) begin
              x_q       <= obj_x_i;
              w_q       <= obj_w_i;
              dy_q      <= dy_d[5:0];
              pal_q     <= obj_pal256_i;
              i_q       <= '0;
              pix_req_q <= (obj_x_i < 9'd240);
              state_q   <= FETCH;
            end else if (last_obj_d) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              idx_q   <= idx_q + 7'd1;
              state_q <= OAM_RD;
            end
          end
          FETCH: begin
            if (!pix_req_q || pix_valid_i) begin
              if (pix_req_q) begin
                buf_we_q    <= !pix_transparent_i;
                buf_wcol_q  <= x_q[7:0] + {2'b00, i_q};
                buf_wdata_q <= pix_data_i;
                buf_pal_q   <= pal_q;
              end
              if (last_px_d) begin
                pix_req_q <= 1'b0;
                if (last_obj_d) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
                end else begin
                  idx_q   <= idx_q + 7'd1;
                  state_q <= OAM_RD;
                end
              end else begin
                i_q       <= i_d;
                pix_req_q <= (col_next_d < 9'd240);
              end
            end
          end
          DONE: begin
            // A line queued by an abort restarts here; a fresh line_start takes precedence.
            if (line_start_i || pend_q) begin
              buf_row_q   <= line_start_i ? line_i : pend_line_q;
              pend_q      <= 1'b0;
              idx_q       <= '0;
              buf_clear_q <= 1'b1;
              state_q     <= CLEAR;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign oam_idx_o         = idx_q;
  assign pix_req_o         = pix_req_q;
  assign pix_obj_o         = idx_q;
  assign pix_line_o        = dy_q;
  assign pix_idx_o         = i_q;
  assign buf_row_o         = buf_row_q;
  assign buf_clear_o       = buf_clear_q;
  assign buf_we_o          = buf_we_q;
  assign buf_wcol_o        = buf_wcol_q;
  assign buf_wdata_o       = buf_wdata_q;
  assign buf_palettemode_o = buf_pal_q;
  assign buf_transparent_o = 1'b0;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign overrun_o         = overrun_q;
endmodule

// File: tb/tb_obj_line_sequencer.sv
// Bench for obj_line_sequencer: OAM and pixel-fetch responders plus a line-level
// reference model that predicts requests, buffer writes, done timing and overrun.
module tb_obj_line_sequencer;
  localparam int BUDGET = 600;
  localparam int NP = 8192;

  logic        clock_i = 1'b0, reset_i = 1'b1, line_start_i = 1'b0;
  logic [7:0]  line_i = '0;
  logic [6:0]  oam_idx_o;
  logic [7:0]  obj_y_i = '0;
  logic [8:0]  obj_x_i = '0;
  logic [6:0]  obj_w_i = '0, obj_h_i = '0;
  logic        obj_disable_i = 1'b1, obj_pal256_i = 1'b0;
  logic        pix_req_o;
  logic [6:0]  pix_obj_o;
  logic [5:0]  pix_line_o, pix_idx_o;
  logic        pix_valid_i = 1'b0;
  logic [15:0] pix_data_i = '0;
  logic        pix_transparent_i = 1'b0;
  logic [7:0]  buf_row_o, buf_wcol_o;
  logic        buf_clear_o, buf_we_o, buf_palettemode_o, buf_transparent_o;
  logic [15:0] buf_wdata_o;
  logic        busy_o, done_o, overrun_o;

  obj_line_sequencer #(.CYCLE_BUDGET(BUDGET)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .line_start_i(line_start_i), .line_i(line_i),
    .oam_idx_o(oam_idx_o), .obj_y_i(obj_y_i), .obj_x_i(obj_x_i), .obj_w_i(obj_w_i),
    .obj_h_i(obj_h_i), .obj_disable_i(obj_disable_i), .obj_pal256_i(obj_pal256_i),
    .pix_req_o(pix_req_o), .pix_obj_o(pix_obj_o), .pix_line_o(pix_line_o), .pix_idx_o(pix_idx_o),
    .pix_valid_i(pix_valid_i), .pix_data_i(pix_data_i), .pix_transparent_i(pix_transparent_i),
    .buf_row_o(buf_row_o), .buf_clear_o(buf_clear_o), .buf_we_o(buf_we_o), .buf_wcol_o(buf_wcol_o),
    .buf_wdata_o(buf_wdata_o), .buf_palettemode_o(buf_palettemode_o),
    .buf_transparent_o(buf_transparent_o), .busy_o(busy_o), .done_o(done_o), .overrun_o(overrun_o)
  );

  always #5 clock_i = ~clock_i;

  // OAM contents and per-request pixel-unit behaviour (indexed by request order within a line)
  logic [7:0]  oam_y[128];
  logic [8:0]  oam_x[128];
  logic [6:0]  oam_w[128], oam_h[128];
  logic        oam_dis[128], oam_pal[128];
  int          waits[NP];
  logic [15:0] pdata[NP];
  logic        trans[NP];

  logic [18:0] exp_req[$];
  logic [25:0] exp_wr[$];
  int exp_done, exp_ov;

  int passes = 0, checks = 0;
  int cyc, r, wcnt, clr_cur, first_clear, done_seen, ov_seen, early_do, clash, nwr;
  logic [7:0] clear_row;
  logic [6:0] prev_idx = '0;
  bit in_req;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Line-level model: 2 cycles per OAM entry, then 1 cycle (+ waits) per pixel of each hit.
  task automatic model(input logic [7:0] ln);
    int t, rq, col;
    logic [7:0] dy;
    exp_req.delete();
    exp_wr.delete();
    t = 0;
    rq = 0;
    for (int k = 0; k < 128; k++) begin
      t += 2;
      dy = ln - oam_y[k];
      if (!oam_dis[k] && dy < {1'b0, oam_h[k]}) begin
        for (int i = 0; i < int'(oam_w[k]); i++) begin
          col = (int'(oam_x[k]) + i) % 512;
          if (col < 240) begin
            exp_req.push_back({7'(k), dy[5:0], 6'(i)});
            if (t + waits[rq % NP] < BUDGET && !trans[rq % NP])
              exp_wr.push_back({8'(col), pdata[rq % NP], oam_pal[k], 1'b0});
            t += waits[rq % NP] + 1;
            rq++;
          end else begin
            t += 1;
          end
        end
      end
    end
    if (t <= BUDGET) begin exp_done = 2 + t; exp_ov = 0; end
    else begin exp_done = 3 + BUDGET; exp_ov = 1; end
  endtask

  task automatic tick();
    logic [25:0] w;
    @(posedge clock_i);
    #1;
    cyc++;
    if (buf_we_o) begin
      nwr++;
      if (exp_wr.size() == 0) chk("unexpected buf_we", 32'(buf_we_o), 32'd0);
      else begin
        w = exp_wr.pop_front();
        chk("write col/data/pal", 32'({buf_wcol_o, buf_wdata_o, buf_palettemode_o, buf_transparent_o}), 32'(w));
      end
    end
    if (buf_we_o && buf_clear_o) clash = 1;
    if (buf_clear_o && first_clear < 0) begin first_clear = cyc; clear_row = buf_row_o; end
    if (cyc == 1) early_do = {30'd0, done_o, overrun_o};
    if (done_o && done_seen < 0 && cyc > clr_cur) begin done_seen = cyc; ov_seen = 32'(overrun_o); end
    obj_y_i = oam_y[prev_idx];
    obj_x_i = oam_x[prev_idx];
    obj_w_i = oam_w[prev_idx];
    obj_h_i = oam_h[prev_idx];
    obj_disable_i = oam_dis[prev_idx];
    obj_pal256_i = oam_pal[prev_idx];
    prev_idx = oam_idx_o;
    pix_valid_i = 1'b0;
    if (pix_req_o) begin
      if (!in_req) begin in_req = 1; wcnt = waits[r % NP]; end
      if (wcnt == 0) begin
        if (r < exp_req.size())
          chk("request obj/line/idx", 32'({pix_obj_o, pix_line_o, pix_idx_o}), 32'(exp_req[r]));
        else
          chk("unexpected pix_req", 32'(pix_req_o), 32'd0);
        pix_valid_i = 1'b1;
        pix_data_i = pdata[r % NP];
        pix_transparent_i = trans[r % NP];
        in_req = 0;
        r++;
      end else begin
        wcnt--;
      end
    end else begin
      in_req = 0;
    end
  endtask

  task automatic begin_line(input logic [7:0] ln, input int clr_at);
    model(ln);
    r = 0; in_req = 0; clash = 0; nwr = 0;
    first_clear = -1; done_seen = -1; ov_seen = -1; early_do = -1;
    clr_cur = clr_at; cyc = 0;
    line_i = ln;
    line_start_i = 1'b1;
    tick();
    line_start_i = 1'b0;
  endtask

  task automatic run_line(input logic [7:0] ln, input int clr_at, input string tag);
    begin_line(ln, clr_at);
    while (done_seen < 0 && cyc < 3000) tick();
    chk({tag, " abort pulse at cycle 1"}, 32'(early_do), (clr_at == 2) ? 32'd3 : 32'd0);
    chk({tag, " buf_clear cycle"}, 32'(first_clear), 32'(clr_at));
    chk({tag, " buf_row"}, 32'(clear_row), 32'(ln));
    chk({tag, " done cycle"}, 32'(done_seen), 32'(exp_done + clr_at - 1));
    chk({tag, " overrun"}, 32'(ov_seen), 32'(exp_ov));
    chk({tag, " writes missing"}, 32'(exp_wr.size()), 32'd0);
    chk({tag, " clear/we clash"}, 32'(clash), 32'd0);
    tick();
    chk({tag, " idle after done"}, 32'(busy_o), 32'd0);
    $display("line %0d %s: writes=%0d done@%0d overrun=%0d", ln, tag, nwr, done_seen, ov_seen);
  endtask

  task automatic clear_oam();
    for (int k = 0; k < 128; k++) begin
      oam_dis[k] = 1'b1; oam_y[k] = '0; oam_x[k] = '0;
      oam_w[k] = 7'd8; oam_h[k] = 7'd8; oam_pal[k] = 1'b0;
    end
    for (int j = 0; j < NP; j++) begin
      waits[j] = 0; pdata[j] = 16'($urandom); trans[j] = 1'b0;
    end
  endtask

  task automatic set_obj(input int k, input int y, input int x, input int w, input int h, input bit pal);
    oam_dis[k] = 1'b0; oam_y[k] = 8'(y); oam_x[k] = 9'(x);
    oam_w[k] = 7'(w); oam_h[k] = 7'(h); oam_pal[k] = pal;
  endtask

  task automatic rand_oam(input logic [7:0] ln);
    for (int k = 0; k < 128; k++) begin
      oam_dis[k] = ($urandom_range(0, 7) != 0);
      oam_y[k]   = ln - 8'($urandom_range(0, 70));
      oam_h[k]   = 7'(8 * $urandom_range(1, 8));
      oam_w[k]   = 7'(8 * $urandom_range(1, 8));
      oam_x[k]   = 9'($urandom_range(0, 511));
      oam_pal[k] = 1'($urandom_range(0, 1));
    end
    for (int j = 0; j < NP; j++) begin
      waits[j] = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      pdata[j] = 16'($urandom);
      trans[j] = ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic check_outs_zero(input string tag);
    chk({tag, " oam/pix outputs"}, 32'({oam_idx_o, pix_req_o, pix_obj_o, pix_line_o, pix_idx_o}), 32'd0);
    chk({tag, " buffer ctl outputs"}, 32'({buf_row_o, buf_clear_o, buf_we_o, buf_wcol_o}), 32'd0);
    chk({tag, " data/status outputs"},
        32'({buf_wdata_o, buf_palettemode_o, buf_transparent_o, busy_o, done_o, overrun_o}), 32'd0);
  endtask

  initial begin
    logic [7:0] ln;
    clear_oam();
    clr_cur = 1; cyc = 0;
    repeat (3) tick();
    check_outs_zero("reset");
    reset_i = 1'b0;
    tick();

    run_line(8'd40, 1, "all disabled");
    chk("all disabled done at 258", 32'(done_seen), 32'd258);
    chk("all disabled no writes", 32'(nwr), 32'd0);

    clear_oam(); set_obj(5, 20, 10, 8, 8, 1'b1);
    run_line(8'd23, 1, "obj5 8x8");

    clear_oam(); set_obj(0, 0, 508, 16, 8, 1'b0);
    run_line(8'd2, 1, "x wrap");

    clear_oam(); set_obj(3, 250, 100, 8, 16, 1'b0);
    run_line(8'd5, 1, "y wrap hit");
    run_line(8'd10, 1, "y wrap miss");

    clear_oam(); set_obj(7, 30, 10, 8, 8, 1'b0); trans[2] = 1'b1;
    run_line(8'd33, 1, "transparent");
    chk("transparent write count", 32'(nwr), 32'd7);

    clear_oam();
    for (int k = 0; k < 10; k++) set_obj(k, 0, 16 * k, 64, 64, k[0]);
    run_line(8'd10, 1, "budget overrun");

    for (int n = 0; n < 6; n++) begin
      ln = 8'($urandom_range(0, 159));
      rand_oam(ln);
      run_line(ln, 1, "random");
    end

    rand_oam(8'd50);
    begin_line(8'd50, 1);
    repeat (20) tick();
    chk("no done before abort", 32'(done_seen), 32'hFFFF_FFFF);
    run_line(8'd60, 2, "abort restart");

    clear_oam(); set_obj(0, 0, 0, 64, 64, 1'b1);
    begin_line(8'd4, 1);
    while (!pix_req_o && cyc < 400) tick();
    chk("reached FETCH before reset", 32'(pix_req_o), 32'd1);
    reset_i = 1'b1;
    tick();
    check_outs_zero("reset mid-fetch");
    reset_i = 1'b0;
    tick();
    chk("idle after reset", 32'({busy_o, pix_req_o}), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/obj_line_sequencer.md
# obj_line_sequencer

Per-scanline controller for the OBJ row double buffer. On each line start it clears the back half of the buffer, then walks OAM entries 0..127 in priority order. For every object that covers the target line, it fetches that line's pixels from the OBJ pixel fetch unit and issues column writes into the buffer. Lower OAM index wins because the buffer only overwrites transparent columns. It sits between OAM, the pixel fetch unit and the row buffer, and works one line ahead of display.

## Interface
Parameters:
- CYCLE_BUDGET, 1210, max cycles from CLEAR to forced DONE per line

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- line_start  in  1  one-cycle pulse: begin building line `line`
- line  in  8  line to build (0..159), sampled on line_start
- oam_idx  out  7  OAM entry address; attributes valid one cycle later
- obj_y  in  8  object top line
- obj_x  in  9  object left column, mod 512
- obj_w  in  7  width in pixels (8..64)
- obj_h  in  7  height in lines (8..64)
- obj_disable  in  1  object not rendered
- obj_pal256  in  1  256-colour mode
- pix_req  out  1  pixel request, held until pix_valid
- pix_obj  out  7  object index of request
- pix_line  out  6  row within object
- pix_idx  out  6  pixel within row
- pix_valid  in  1  request accepted, data valid this cycle
- pix_data  in  16  pixel data
- pix_transparent  in  1  pixel is transparent
- buf_row  out  8  latched line, drives buffer half select
- buf_clear  out  1  clear pulse
- buf_we  out  1  column write
- buf_wcol  out  8  write column (always <240 when buf_we)
- buf_wdata  out  16  write data
- buf_palettemode  out  1  obj_pal256 of the object being written
- buf_transparent  out  1  constant 0 on writes
- busy  out  1  line in progress
- done  out  1  one-cycle pulse at line completion
- overrun  out  1  one-cycle pulse with done when budget expired or line aborted

## Operation
- States: IDLE, CLEAR, OAM_RD, OAM_CHK, FETCH, DONE.
- IDLE: on line_start, latch line into buf_row, set idx=0, go to CLEAR.
- CLEAR: buf_clear=1 for one cycle, budget counter=0, go to OAM_RD.
- OAM_RD: oam_idx=idx, go to OAM_CHK.
- OAM_CHK: compute dy = (buf_row − obj_y) mod 256, 8-bit.
  - Hit = !obj_disable && dy < obj_h.
  - On hit: latch x, w, dy and pal256; set i=0; go to FETCH.
  - On miss: if idx=127 go to DONE, else idx+1 and go to OAM_RD.
- FETCH: col = (x + i) mod 512.
  - If col ≥ 240: no pix_req; advance i one per cycle.
  - Else: assert pix_req with pix_obj=idx, pix_line=dy[5:0], pix_idx=i, held stable until pix_valid.
  - On pix_valid: register a write with buf_wcol=col, buf_wdata=pix_data, buf_palettemode=pal256, buf_we=!pix_transparent; then advance i.
  - After i=w−1: if idx=127 go to DONE, else idx+1 and go to OAM_RD.
- DONE: done=1 for one cycle, go to IDLE. buf_row is held until the next line_start.
- Budget: the counter increments every cycle after CLEAR. When it reaches CYCLE_BUDGET in any non-DONE state, go to DONE and pulse overrun with done. A write already registered still issues; an outstanding pix_req drops.
- line_start while busy: abort the current line, pulse done+overrun that cycle, then re-enter CLEAR with the new line.
- Reset: state IDLE, all outputs 0, buf_row=0, counters 0.

## Timing
- line_start sampled in cycle 0 (IDLE).
  - Cycle 1: buf_clear.
  - Cycle 2: oam_idx=0.
  - Cycle 3: attributes checked.
- A miss costs 2 cycles per entry. An all-miss line gives done in cycle 258; busy is high for cycles 1..258.
- pix_valid may arrive in the first cycle of pix_req (zero wait). The matching buf_we appears the next cycle.
- Each in-range pixel costs 1 cycle plus wait states; each off-screen pixel costs 1 cycle.
- buf_clear and buf_we are never high together.
- Outputs are registered; there are no combinational paths from pix_valid to buf_*.

## Test plan
- All OAM disabled, line_start line=40 -> buf_clear in cycle 1, done in cycle 258, overrun=0, no buf_we.
- Obj 5: y=20, x=10, 8x8, line=23, pix_valid immediate -> pix_line=3; 8 buf_we at cols 10..17 in idx order; done=1, overrun=0.
- Obj 0: x=508, w=16, y=0, h=8, line=2 -> 4 skipped cycles with no pix_req, then writes at cols 0..11 for pix_idx 4..15.
- Vertical wrap: obj y=250, h=16, line=5 -> hit with pix_line=11. Same object with line=10 -> miss (dy=16).
- pix_transparent=1 on pix_idx 2 -> no buf_we for that column, all others written. CYCLE_BUDGET=100 with a 64-wide object -> done+overrun at counter 100, no further pix_req.
- Reset asserted mid-FETCH -> next cycle IDLE, all outputs 0. line_start while busy -> done+overrun pulse, then buf_clear with the new buf_row.
